// File: rtl/ysyx_23060042_seq.sv
// Multi-cycle instruction sequencer: fetch, decode-dispatch, optional memory access, writeback.
// Latency: 4 cycles per ALU retire, 6 per load/store when handshakes complete immediately.
// Backpressure: stalls in FETCH_REQ/MEM_REQ until ready; FETCH_WAIT halts after TIMEOUT idle cycles.
module ysyx_23060042_seq #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    input  logic        ifu_rsp_valid,
    input  logic [31:0] ifu_rdata,
    output logic [31:0] inst_q,
    input  logic        regen_i,
    output logic        lsu_req_valid,
    input  logic        lsu_req_ready,
    output logic        lsu_wen,
    input  logic        lsu_rsp_valid,
    output logic        rf_we,
    output logic        pc_we,
    output logic        retire,
    output logic        busy,
    output logic        halted,
    output logic        halt_code,
    output logic [31:0] retire_cnt
);

    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [31:0] INST_EBRK = 32'h00100073;
    localparam logic [31:0] INST_NOP  = 32'h00000013;
    localparam logic [7:0]  WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_REQ,
        FETCH_WAIT,
        EXEC,
        MEM_REQ,
        MEM_WAIT,
        WB,
        HALT
    } state_t;

    state_t     state;
    logic [7:0] wait_cnt;
    logic       is_load;
    logic       is_store;

    assign is_load  = (inst_q[6:0] == OP_LOAD);
    assign is_store = (inst_q[6:0] == OP_STORE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            inst_q     <= INST_NOP;
            wait_cnt   <= 8'd0;
            halt_code  <= 1'b0;
            retire_cnt <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= FETCH_REQ;
                end
                FETCH_REQ: begin
                    if (ifu_req_ready) begin
                        state    <= FETCH_WAIT;
                        wait_cnt <= 8'd0;
                    end
                end
                FETCH_WAIT: begin
                    // A response on the limit cycle still wins over the timeout.
                    if (ifu_rsp_valid) begin
                        inst_q <= ifu_rdata;
                        state  <= EXEC;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state     <= HALT;
                        halt_code <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                EXEC: begin
                    if (inst_q == INST_EBRK) begin
                        state     <= HALT;
                        halt_code <= 1'b0;
                    end else if (is_load || is_store) begin
                        state <= MEM_REQ;
                    end else begin
                        state <= WB;
                    end
                end
                MEM_REQ: begin
                    if (lsu_req_ready) state <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    if (lsu_rsp_valid) state <= WB;
                end
                WB: begin
                    retire_cnt <= retire_cnt + 32'd1;
                    state      <= FETCH_REQ;
                end
                HALT: begin
                    state <= HALT;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode straight from the state flop, so they drop with reset immediately.
    assign ifu_req_valid = (state == FETCH_REQ);
    assign lsu_req_valid = (state == MEM_REQ);
    assign lsu_wen       = (state == MEM_REQ) && is_store;
    assign pc_we         = (state == WB);
    assign retire        = (state == WB);
    assign rf_we         = (state == WB) && regen_i && !is_store && (inst_q[11:7] != 5'd0);
    assign halted        = (state == HALT);
    assign busy          = (state != IDLE) && (state != HALT);

endmodule

// File: tb/tb_ysyx_23060042_seq.sv
// Directed bench for the sequencer: an instruction table plus hand sequences for halt, timeout and reset.
module tb_ysyx_23060042_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        ifu_req_ready = 1'b0;
    logic        ifu_rsp_valid = 1'b0;
    logic [31:0] ifu_rdata = 32'd0;
    logic        regen_i = 1'b0;
    logic        lsu_req_ready = 1'b0;
    logic        lsu_rsp_valid = 1'b0;
    logic        ifu_req_valid, lsu_req_valid, lsu_wen;
    logic        rf_we, pc_we, retire, busy, halted, halt_code;
    logic [31:0] inst_q, retire_cnt;

    ysyx_23060042_seq #(.TIMEOUT(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rdata     (ifu_rdata),
        .inst_q        (inst_q),
        .regen_i       (regen_i),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_wen       (lsu_wen),
        .lsu_rsp_valid (lsu_rsp_valid),
        .rf_we         (rf_we),
        .pc_we         (pc_we),
        .retire        (retire),
        .busy          (busy),
        .halted        (halted),
        .halt_code     (halt_code),
        .retire_cnt    (retire_cnt)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_cnt = 32'd0;

    typedef struct {
        logic [31:0] inst;
        logic        regen;
        int          stall;
        logic        exp_rf;
        logic        exp_wen;
        int          exp_cyc;
        int          exp_lsu;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Services both handshakes for one instruction starting at FETCH_REQ; returns at next FETCH_REQ.
    task automatic run_inst(input int idx, input vec_t v);
        int   cyc = 0;
        int   lsu_cyc = 0;
        int   stall = v.stall;
        bit   f_pend = 0, m_pend = 0, done = 0, not_busy = 0;
        logic wen_seen = 0, rf_seen = 0, pc_seen = 0;
        ifu_rdata = v.inst;
        regen_i   = v.regen;
        while (!done && cyc < 40) begin
            cyc++;
            if (!busy) not_busy = 1;
            ifu_rsp_valid = f_pend;
            f_pend        = 0;
            lsu_rsp_valid = m_pend;
            m_pend        = 0;
            ifu_req_ready = 0;
            lsu_req_ready = 0;
            if (ifu_req_valid) begin
                ifu_req_ready = 1;
                f_pend        = 1;
            end
            if (lsu_req_valid) begin
                lsu_cyc++;
                if (lsu_wen) wen_seen = 1;
                if (stall > 0) stall--;
                else begin
                    lsu_req_ready = 1;
                    m_pend        = 1;
                end
            end
            if (retire) begin
                done    = 1;
                rf_seen = rf_we;
                pc_seen = pc_we;
            end
            @(negedge clk);
        end
        ifu_rsp_valid = 0;
        lsu_rsp_valid = 0;
        ifu_req_ready = 0;
        lsu_req_ready = 0;
        if (done) exp_cnt = exp_cnt + 32'd1;
        chk($sformatf("v%0d_cycles", idx), cyc, v.exp_cyc);
        chk($sformatf("v%0d_lsu_vld_cycles", idx), lsu_cyc, v.exp_lsu);
        chk($sformatf("v%0d_lsu_wen", idx), wen_seen, v.exp_wen);
        chk($sformatf("v%0d_rf_we", idx), rf_seen, v.exp_rf);
        chk($sformatf("v%0d_pc_we", idx), pc_seen, 1);
        chk($sformatf("v%0d_busy", idx), not_busy, 0);
        chk($sformatf("v%0d_retire_cnt", idx), retire_cnt, exp_cnt);
    endtask

    task automatic fetch(input logic [31:0] inst, input bit give_rsp);
        chk("fetch_req_vld", ifu_req_valid, 1);
        ifu_req_ready = 1;
        @(negedge clk);
        ifu_req_ready = 0;
        if (give_rsp) begin
            ifu_rdata     = inst;
            ifu_rsp_valid = 1;
            @(negedge clk);
            ifu_rsp_valid = 0;
        end
    endtask

    task automatic reset_start();
        rst_n = 0;
        @(negedge clk);
        rst_n   = 1;
        exp_cnt = 32'd0;
        start   = 1;
        @(negedge clk);
        start = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h00100093, 1'b1, 0, 1'b1, 1'b0, 4, 0};  // addi x1
        vecs[1] = '{32'h0000A103, 1'b1, 3, 1'b1, 1'b0, 9, 4};  // lw x2, stalled
        vecs[2] = '{32'h00112023, 1'b1, 0, 1'b0, 1'b1, 6, 1};  // sw
        vecs[3] = '{32'h00000013, 1'b1, 0, 1'b0, 1'b0, 4, 0};  // addi x0
        vecs[4] = '{32'h002081B3, 1'b0, 0, 1'b0, 1'b0, 4, 0};  // add, no regen
        vecs[5] = '{32'h00002003, 1'b1, 1, 1'b0, 1'b0, 7, 2};  // lw x0
        vecs[6] = '{32'h00112023, 1'b0, 2, 1'b0, 1'b1, 8, 3};  // sw, stalled

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_halt_code", halt_code, 0);
        chk("rst_retire_cnt", retire_cnt, 0);
        chk("rst_inst_q", inst_q, 32'h00000013);
        chk("rst_ifu_vld", ifu_req_valid, 0);
        chk("rst_lsu_vld", lsu_req_valid, 0);
        chk("rst_retire", retire, 0);

        @(negedge clk);
        rst_n         = 1;
        ifu_rdata     = 32'h00100073;
        ifu_rsp_valid = 1;
        lsu_rsp_valid = 1;
        repeat (3) @(negedge clk);
        chk("idle_inst_q", inst_q, 32'h00000013);
        chk("idle_busy", busy, 0);
        chk("idle_ifu_vld", ifu_req_valid, 0);
        ifu_rsp_valid = 0;
        lsu_rsp_valid = 0;

        start = 1;
        @(negedge clk);
        start = 0;
        chk("start_ifu_vld", ifu_req_valid, 1);
        chk("start_busy", busy, 1);

        for (int i = 0; i < 7; i++) run_inst(i, vecs[i]);

        fetch(32'h00100073, 1);
        chk("ebreak_exec_retire", retire, 0);
        @(negedge clk);
        chk("ebreak_halted", halted, 1);
        chk("ebreak_code", halt_code, 0);
        chk("ebreak_busy", busy, 0);
        chk("ebreak_cnt", retire_cnt, exp_cnt);
        start = 1;
        repeat (3) @(negedge clk);
        start = 0;
        chk("halt_sticky", halted, 1);
        chk("halt_ifu_vld", ifu_req_valid, 0);
        chk("halt_cnt", retire_cnt, exp_cnt);

        reset_start();
        fetch(32'd0, 0);
        repeat (3) @(negedge clk);
        chk("to_not_yet", halted, 0);
        @(negedge clk);
        chk("to_halted", halted, 1);
        chk("to_code", halt_code, 1);
        chk("to_busy", busy, 0);

        reset_start();
        fetch(32'd0, 0);
        repeat (3) @(negedge clk);
        ifu_rdata     = 32'h00100093;
        regen_i       = 1;
        ifu_rsp_valid = 1;
        @(negedge clk);
        ifu_rsp_valid = 0;
        chk("edge_no_halt", halted, 0);
        chk("edge_busy", busy, 1);
        @(negedge clk);
        chk("edge_retire", retire, 1);
        chk("edge_rf_we", rf_we, 1);
        @(negedge clk);
        chk("edge_cnt", retire_cnt, 1);

        reset_start();
        run_inst(7, vecs[0]);
        fetch(32'h0000A103, 1);
        @(negedge clk);
        chk("mw_lsu_vld", lsu_req_valid, 1);
        lsu_req_ready = 1;
        @(negedge clk);
        lsu_req_ready = 0;
        chk("mw_state_vld", lsu_req_valid, 0);
        chk("mw_ifu_vld", ifu_req_valid, 0);
        regen_i       = 1;
        lsu_rsp_valid = 1;
        rst_n         = 0;
        #1;
        chk("mwrst_busy", busy, 0);
        chk("mwrst_cnt", retire_cnt, 0);
        chk("mwrst_inst_q", inst_q, 32'h00000013);
        chk("mwrst_retire", retire, 0);
        chk("mwrst_rf_we", rf_we, 0);
        @(negedge clk);
        lsu_rsp_valid = 0;
        rst_n         = 1;
        repeat (3) @(negedge clk);
        chk("post_rst_cnt", retire_cnt, 0);
        chk("post_rst_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_23060042_seq.md
YSYX_23060042_SEQ -- requirements
Module: ysyx_23060042_seq

Interface
REQ-001 SHALL have ports: clk  in  1  core clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset; asynchronous assert, active-low.
REQ-003 SHALL have ports: start  in  1  leave IDLE and begin fetching.
REQ-004 SHALL have ports: ifu_req_valid  out  1 / ifu_req_ready  in  1  fetch request handshake.
REQ-005 SHALL have ports: ifu_rsp_valid  in  1 / ifu_rdata  in  32  fetch response, single-cycle pulse.
REQ-006 SHALL have ports: inst_q  out  32  latched instruction driven to decoder.
REQ-007 SHALL have ports: regen_i  in  1  decoder register-write enable.
REQ-008 SHALL have ports: lsu_req_valid  out  1 / lsu_req_ready  in  1 / lsu_wen  out  1  memory request handshake; lsu_wen=1 for store.
REQ-009 SHALL have ports: lsu_rsp_valid  in  1  memory access complete.
REQ-010 SHALL have ports: rf_we  out  1 / pc_we  out  1 / retire  out  1  writeback strobes.
REQ-011 SHALL have ports: busy  out  1 / halted  out  1 / halt_code  out  1 (0=ebreak, 1=fetch timeout) / retire_cnt  out  32.
REQ-012 SHALL have parameter: TIMEOUT, default 255, fetch-wait cycle limit (range 1..255).

Function
REQ-013 SHALL implement states IDLE, FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT.
REQ-014 IDLE: all strobes 0, busy=0; start=1 -> FETCH_REQ next edge.
REQ-015 FETCH_REQ: ifu_req_valid=1 (Moore); ifu_req_valid&ifu_req_ready -> FETCH_WAIT; stays asserted until accepted.
REQ-016 FETCH_WAIT: ifu_rsp_valid=1 -> inst_q<=ifu_rdata, -> EXEC; wait counter (8-bit) cleared on entry, +1 per cycle without rsp.
REQ-017 FETCH_WAIT timeout: counter reaching TIMEOUT without rsp -> HALT, halt_code=1; rsp in same cycle as limit takes priority (no halt).
REQ-018 EXEC (1 cycle): inst_q==32'h00100073 -> HALT, halt_code=0, no retire; opcode 0000011 (load) or 0100011 (store) -> MEM_REQ; otherwise -> WB.
REQ-019 MEM_REQ: lsu_req_valid=1, lsu_wen=1 iff store opcode; accepted (valid&ready) -> MEM_WAIT.
REQ-020 MEM_WAIT: lsu_rsp_valid=1 -> WB; no timeout; ifu signals held 0.
REQ-021 WB (1 cycle): pc_we=1, retire=1, rf_we=regen_i & ~store & (inst_q[11:7]!=0); -> FETCH_REQ.
REQ-022 retire_cnt SHALL increment by 1 on each retire, wrap 32'hFFFFFFFF -> 0.
REQ-023 HALT sticky until rst_n; halted=1, busy=0, all strobes 0, start ignored.
REQ-024 busy=1 in every state except IDLE and HALT.
REQ-025 Responses arriving outside their wait state (ifu_rsp_valid outside FETCH_WAIT, lsu_rsp_valid outside MEM_WAIT) SHALL be ignored.
REQ-026 Latency, no-memory instruction with ready/rsp immediate: FETCH_REQ, FETCH_WAIT, EXEC, WB = 4 cycles per retire; load/store = 6.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, inst_q=32'h00000013, retire_cnt=0, halted=0, halt_code=0, wait counter 0, all strobes 0.
REQ-028 Reset asserted mid-handshake SHALL abandon it; no retire or rf_we for the interrupted instruction.
REQ-029 First transition after rst_n deassert SHALL occur on the next rising edge with start=1.

Verification
REQ-030 start=1, ready=1, rsp next cycle with 32'h00100093 (addi x1), regen_i=1 -> rf_we=pc_we=retire=1 in cycle 4, retire_cnt=1.
REQ-031 Fetch 32'h0000A103 (lw x2), lsu_req_ready held 0 for 3 cycles, then rsp -> lsu_req_valid held 4 cycles, lsu_wen=0, rf_we=1 in WB.
REQ-032 Fetch 32'h00112023 (sw), regen_i=1 -> lsu_wen=1, rf_we=0, pc_we=1.
REQ-033 Fetch 32'h00100073 -> halted=1, halt_code=0, retire_cnt unchanged, start ignored thereafter.
REQ-034 TIMEOUT=4, ifu_rsp_valid never asserted -> HALT with halt_code=1 after 4 FETCH_WAIT cycles; repeat with rsp exactly at 4th cycle -> no halt.
REQ-035 Deassert rst_n in MEM_WAIT -> all outputs reset values same cycle; retire_cnt=0.
